uart_rx_frame_sampler: RTL

//  Parametrised UART RX front end: synchronises RX_IN, oversamples each bit, takes a 3-sample

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_majority3.sv | 30 +++
 rtl/uart_rx_frame_sampler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared FSM encoding, legal oversampling ratios and the 3-input vote used by the UART RX front end.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Captures the synchronised line at P/2-1, P/2 and P/2+1 of each bit and votes 2-of-3.
module uart_rx_majority3
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  active,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] half,
  output logic                  maj
);

  logic [2:0] smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
    end else if (active) begin
      if (edge_cnt == (half - PRESCALE_W'(1))) smp[0] <= rx;
      if (edge_cnt == half)                    smp[1] <= rx;
      if (edge_cnt == (half + PRESCALE_W'(1))) smp[2] <= rx;
    end
  end

  assign maj = maj3(smp[0], smp[1], smp[2]);

endmodule

// File: rtl/uart_rx_frame_sampler.sv
// UART RX front end: line synchroniser, oversampling counters, majority-voted bit sampling and
// frame deserialiser with parity/stop checking.
module uart_rx_frame_sampler
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  rx_state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic [PRESCALE_W-1:0]   presc_l;
  logic [PRESCALE_W-1:0]   half;
  logic                    par_en_l, par_typ_l;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_fail;
  logic                    bit_hold;
  logic                    maj;
  logic                    wrap, sv_point, resolve_pt, start_det;

  // Unsupported ratios fall back to the slowest-sampling legal setting.
  function automatic logic [PRESCALE_W-1:0] legal_presc(input logic [PRESCALE_W-1:0] p);
    if (p == PRESCALE_W'(PRESC_8) || p == PRESCALE_W'(PRESC_16) || p == PRESCALE_W'(PRESC_32))
      return p;
    return PRESCALE_W'(PRESC_8);
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign half       = presc_l >> 1;
  assign wrap       = (edge_cnt == (presc_l - PRESCALE_W'(1)));
  assign sv_point   = (edge_cnt == (half + PRESCALE_W'(2)));
  assign resolve_pt = (edge_cnt == (half + PRESCALE_W'(3)));
  assign start_det  = (state == ST_IDLE) && enable && !rx_s;

  uart_rx_majority3 #(.PRESCALE_W(PRESCALE_W)) u_maj (
    .clk      (CLK),
    .rst_n    (RST),
    .active   (busy),
    .rx       (rx_s),
    .edge_cnt (edge_cnt),
    .half     (half),
    .maj      (maj)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (!rx_s) state_nxt = ST_START;
        ST_START: begin
          if (sample_valid && maj) state_nxt = ST_IDLE;
          else if (wrap)           state_nxt = ST_DATA;
        end
        ST_DATA:   if (wrap && bit_cnt == LAST_DATA) state_nxt = par_en_l ? ST_PARITY : ST_STOP;
        ST_PARITY: if (wrap) state_nxt = ST_STOP;
        // Leave mid stop bit so a back-to-back start edge is not missed.
        ST_STOP:   if (resolve_pt || wrap) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != ST_IDLE);
    sample_valid = busy && sv_point;
    sampled_bit  = sample_valid ? maj : bit_hold;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_l    <= PRESCALE_W'(PRESC_8);
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      shreg      <= '0;
      par_fail   <= 1'b0;
      bit_hold   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state == ST_IDLE || state_nxt == ST_IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end

      if (sample_valid) bit_hold <= maj;

      if (!enable) begin
        shreg    <= '0;
        par_fail <= 1'b0;
      end else if (start_det) begin
        presc_l   <= legal_presc(Prescale);
        par_en_l  <= par_en;
        par_typ_l <= par_typ;
        shreg     <= '0;
        par_fail  <= 1'b0;
      end else if (sample_valid) begin
        case (state)
          ST_DATA:   shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          ST_PARITY: par_fail <= (maj != (^shreg ^ par_typ_l));
          // Frame outcome is registered here and shows during the following cycle.
          ST_STOP: begin
            stp_err    <= ~maj;
            par_err    <= par_fail;
            data_valid <= maj & ~par_fail;
            if (maj && !par_fail) P_DATA <= shreg;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
